full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 13 +
 rtl/full_adder_bit.sv | 15 +
 rtl/full_adder.sv | 66 ++++++
 tb/tb_full_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared arithmetic constants and helpers for the full_adder datapath.
package full_adder_pkg;

    // Legal operand width range for the ripple-carry adder.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // True when a requested adder width lies inside the supported range.
    function automatic bit width_ok(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full adder cell; chained by the top level.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the three inputs.
    assign s    = a ^ b ^ cin;
    // Carry is the majority of the three inputs.
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Clocked WIDTH-bit ripple-carry adder: {Cout, S} = A + B + Cin, one cycle
// of latency, synchronous active-low reset, outputs hold when idle.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             valid_out
);

    // Reject unsupported widths while elaborating rather than building a
    // silently wrong adder.
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("full_adder: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             valid_reg;

    assign carry[0] = Cin;

    // Ripple chain of identical 1-bit cells, LSB first.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_adder_bit u_bit (
            .a    (A[gi]),
            .b    (B[gi]),
            .cin  (carry[gi]),
            .s    (sum_bits[gi]),
            .cout (carry[gi+1])
        );
    end

    // Output register: reset clears everything and beats a same-edge
    // valid_in; otherwise load on valid_in and hold the result when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_in;
            if (valid_in) begin
                s_reg    <= sum_bits;
                cout_reg <= carry[WIDTH];
            end
        end
    end

    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8. Inputs change on the
// falling edge and outputs are read on the next falling edge, i.e. half a
// cycle after the rising edge that registered them.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       valid1, a1, b1, cin1;
    logic       s1, cout1, vout1;

    logic       valid8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] s8;
    logic       cout8, vout8;

    int total = 0;
    int bad   = 0;

    // Hand-written truth table indexed by {A,B,Cin}.
    logic [7:0] tt_s = 8'b1001_0110;
    logic [7:0] tt_c = 8'b1110_1000;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid1),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
        .S         (s1),
        .Cout      (cout1),
        .valid_out (vout1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid8),
        .A         (a8),
        .B         (b8),
        .Cin       (cin8),
        .S         (s8),
        .Cout      (cout8),
        .valid_out (vout8)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({s1, cout1, vout1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_w1: got S=%b Cout=%b valid=%b, want 0 0 0", s1, cout1, vout1);
        end
        total++;
        if ({s8, cout8, vout8} !== 10'b0) begin
            bad++;
            $display("FAIL reset_w8: got S=%h Cout=%b valid=%b, want 00 0 0", s8, cout8, vout8);
        end
        $display("txn reset: w1 S=%b Cout=%b v=%b w8 S=%h Cout=%b v=%b", s1, cout1, vout1, s8, cout8, vout8);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            valid1 = 1'b1;
            @(negedge clk);
            total++;
            if ({s1, cout1, vout1} !== {tt_s[i], tt_c[i], 1'b1}) begin
                bad++;
                $display("FAIL truth_%0d: got S=%b Cout=%b valid=%b, want %b %b 1",
                         i, s1, cout1, vout1, tt_s[i], tt_c[i]);
            end
            $display("txn truth abc=%03b: S=%b Cout=%b valid=%b", 3'(i), s1, cout1, vout1);
        end
        valid1 = 1'b0;
    endtask

    task automatic test_reset_override();
        // Preceding table ended on 1+1+1, so S=1/Cout=1 are held going in.
        rst_n = 1'b0;
        valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        total++;
        if ({s1, cout1, vout1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_wins_w1: got S=%b Cout=%b valid=%b, want 0 0 0", s1, cout1, vout1);
        end
        total++;
        if ({s8, cout8, vout8} !== 10'b0) begin
            bad++;
            $display("FAIL reset_wins_w8: got S=%h Cout=%b valid=%b, want 00 0 0", s8, cout8, vout8);
        end
        $display("txn reset_wins: w1 S=%b Cout=%b v=%b w8 S=%h Cout=%b v=%b", s1, cout1, vout1, s8, cout8, vout8);
        rst_n = 1'b1;
        valid1 = 1'b0;
        valid8 = 1'b0;
    endtask

    task automatic test_hold();
        valid1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        total++;
        if ({s1, cout1, vout1} !== 3'b101) begin
            bad++;
            $display("FAIL hold_load: got S=%b Cout=%b valid=%b, want 1 0 1", s1, cout1, vout1);
        end
        $display("txn hold_load: S=%b Cout=%b valid=%b", s1, cout1, vout1);
        valid1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({s1, cout1, vout1} !== 3'b100) begin
                bad++;
                $display("FAIL hold_%0d: got S=%b Cout=%b valid=%b, want 1 0 0", i, s1, cout1, vout1);
            end
            $display("txn hold_%0d: S=%b Cout=%b valid=%b", i, s1, cout1, vout1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wa  [3] = '{8'hFF, 8'h7F, 8'hFF};
        logic [7:0] wb  [3] = '{8'h01, 8'h01, 8'hFF};
        logic       wc  [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] ws  [3] = '{8'h00, 8'h80, 8'hFF};
        logic       wco [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            valid8 = 1'b1; a8 = wa[i]; b8 = wb[i]; cin8 = wc[i];
            @(negedge clk);
            total++;
            if ({s8, cout8, vout8} !== {ws[i], wco[i], 1'b1}) begin
                bad++;
                $display("FAIL wrap_%0d: got S=%h Cout=%b valid=%b, want %h %b 1",
                         i, s8, cout8, vout8, ws[i], wco[i]);
            end
            $display("txn wrap %h+%h+%b: S=%h Cout=%b valid=%b", wa[i], wb[i], wc[i], s8, cout8, vout8);
        end
        valid8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp9;
        logic       in_reset;
        for (int i = 0; i < 1000; i++) begin
            in_reset = (i == 500);
            rst_n  = !in_reset;
            valid8 = 1'b1;
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom);
            exp9   = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
            @(negedge clk);
            total++;
            if (in_reset) begin
                if ({s8, cout8, vout8} !== 10'b0) begin
                    bad++;
                    $display("FAIL b2b_reset_%0d: got S=%h Cout=%b valid=%b, want 00 0 0", i, s8, cout8, vout8);
                end
            end else if ({cout8, s8, vout8} !== {exp9, 1'b1}) begin
                bad++;
                $display("FAIL b2b_%0d: got Cout=%b S=%h valid=%b, want %b %h 1",
                         i, cout8, s8, vout8, exp9[8], exp9[7:0]);
            end
            $display("txn b2b %0d rst=%b: Cout=%b S=%h valid=%b", i, in_reset, cout8, s8, vout8);
        end
        rst_n  = 1'b1;
        valid8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_reset_override();
        test_hold();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
